// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared state encoding and direction constants for the snake game loop
package snake_pkg;

    typedef enum logic [3:0] {
        IDLE, INIT, LOAD, WAIT, FOOD, MOVE, PREV, RD,
        SWAP, RD2, DRAW, ADV, CHECK, GROW, DEADCHK, DEAD
    } state_t;

    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam logic [2:0] DIR_DOWN  = 3'b110;
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;

    localparam int PIX_PER_SEG = 9;

    function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
        return (a == DIR_UP    && b == DIR_DOWN)  || (a == DIR_DOWN  && b == DIR_UP) ||
               (a == DIR_LEFT  && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT);
    endfunction

endpackage

// File: rtl/snake_frame_timer.sv
// rtl/snake_frame_timer.sv - frame pacing counter, pulses done on its last count
module snake_frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(FRAME_CYCLES);

    logic [CW-1:0] count;

    assign done = enable && (count == CW'(FRAME_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/snake_control.sv
// rtl/snake_control.sv - game-loop sequencer driving the snake datapath strobes
module snake_control
    import snake_pkg::*;
#(
    parameter int INIT_LEN     = 4,
    parameter int MAX_LEN      = 64,
    parameter int FRAME_CYCLES = 833333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        isDead,
    input  logic        inc_length,
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        draw_q,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic        draw_curr,
    output logic        food_en,
    output logic        check_inc,
    output logic        lock,
    output logic [3:0]  cnt_status,
    output logic [2:0]  dir,
    output logic [10:0] length
);

    state_t      state;
    logic [10:0] seg;
    logic [3:0]  pix;
    logic [2:0]  pending_dir;
    logic        frame_done;
    logic        timer_clear;
    logic        timer_en;
    logic        any_key;

    assign any_key     = key_up | key_down | key_left | key_right;
    assign timer_en    = (state == WAIT);
    assign timer_clear = (state != WAIT);

    snake_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .done   (frame_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            seg         <= '0;
            pix         <= '0;
            length      <= 11'(INIT_LEN);
            dir         <= DIR_UP;
            pending_dir <= DIR_UP;
        end else begin
            if (state != IDLE && state != DEAD) begin
                if (key_up)         pending_dir <= DIR_UP;
                else if (key_down)  pending_dir <= DIR_DOWN;
                else if (key_left)  pending_dir <= DIR_LEFT;
                else if (key_right) pending_dir <= DIR_RIGHT;
            end
            case (state)
                IDLE:  if (go) state <= INIT;
                INIT: begin
                    seg    <= '0;
                    length <= 11'(INIT_LEN);
                    dir    <= DIR_UP;
                    state  <= LOAD;
                end
                LOAD: begin
                    if (seg == 11'(INIT_LEN - 1)) begin
                        seg   <= '0;
                        state <= WAIT;
                    end else begin
                        seg <= seg + 11'd1;
                    end
                end
                WAIT:  if (frame_done) state <= FOOD;
                FOOD:  state <= MOVE;
                MOVE: begin
                    if (!is_opposite(pending_dir, dir)) dir <= pending_dir;
                    state <= PREV;
                end
                PREV: begin
                    seg   <= '0;
                    state <= RD;
                end
                RD:    state <= SWAP;
                SWAP:  state <= RD2;
                RD2: begin
                    pix   <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    if (pix == 4'(PIX_PER_SEG - 1)) begin
                        pix   <= '0;
                        state <= ADV;
                    end else begin
                        pix <= pix + 4'd1;
                    end
                end
                ADV: begin
                    if (seg == length - 11'd1) begin
                        state <= CHECK;
                    end else begin
                        seg   <= seg + 11'd1;
                        state <= RD;
                    end
                end
                CHECK: state <= (inc_length && length < 11'(MAX_LEN)) ? GROW : DEADCHK;
                GROW: begin
                    length <= length + 11'd1;
                    state  <= DEADCHK;
                end
                DEADCHK: state <= isDead ? DEAD : WAIT;
                DEAD:    if (go) state <= INIT;
            endcase
        end
    end

    // Moore decode: a reset forces IDLE and therefore silences every strobe at once.
    always_comb begin
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        draw_q            = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        food_en           = 1'b0;
        check_inc         = 1'b0;
        lock              = 1'b0;
        cnt_status        = 4'd0;
        case (state)
            INIT: begin
                ld_head     = 1'b1;
                rst_address = 1'b1;
            end
            LOAD: begin
                ld_q_def    = 1'b1;
                inc_address = 1'b1;
            end
            WAIT:  lock = any_key;
            FOOD:  food_en = 1'b1;
            MOVE: begin
                update_head = 1'b1;
                rst_address = 1'b1;
            end
            PREV:  ld_head_into_prev = 1'b1;
            SWAP: begin
                ld_q_into_curr = 1'b1;
                ld_prev_into_q = 1'b1;
            end
            DRAW: begin
                draw_q     = 1'b1;
                cnt_status = pix;
            end
            ADV: begin
                ld_curr_into_prev = 1'b1;
                inc_address       = 1'b1;
            end
            CHECK: check_inc      = 1'b1;
            GROW:  ld_prev_into_q = 1'b1;
            default: ;
        endcase
    end

    assign draw_curr = 1'b0;

endmodule

// File: tb/tb_snake_control.sv
// tb/tb_snake_control.sv - directed self-checking bench for snake_control
module tb_snake_control;

    logic        clk = 1'b0;
    logic        rst, go, key_up, key_down, key_left, key_right, isDead, inc_length;
    logic        ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head;
    logic        ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
    logic        draw_curr, food_en, check_inc, lock;
    logic [3:0]  cnt_status;
    logic [2:0]  dir;
    logic [10:0] length;
    logic [13:0] strb;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign strb = {ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
                   ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
                   draw_curr, food_en, check_inc, lock};

    snake_control #(.INIT_LEN(4), .MAX_LEN(5), .FRAME_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .go(go),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .isDead(isDead), .inc_length(inc_length),
        .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address),
        .rst_address(rst_address), .draw_q(draw_q), .update_head(update_head),
        .ld_head_into_prev(ld_head_into_prev), .ld_q_into_curr(ld_q_into_curr),
        .ld_prev_into_q(ld_prev_into_q), .ld_curr_into_prev(ld_curr_into_prev),
        .draw_curr(draw_curr), .food_en(food_en), .check_inc(check_inc), .lock(lock),
        .cnt_status(cnt_status), .dir(dir), .length(length)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // From the next FOOD: cycles to CHECK, draw/advance counts, pixel order errors,
    // growth strobe right after CHECK, and cycles from CHECK to the following FOOD.
    task automatic run_frame(output int to_check, output int draws, output int advs,
                             output int seq_err, output int grew, output int gap);
        int n;
        logic [3:0] exp_pix;
        to_check = -1; draws = 0; advs = 0; seq_err = 0; grew = 0; gap = -1;
        n = 0;
        while (!food_en && n < 200) begin tick(); n++; end
        if (food_en) begin
            n = 0;
            exp_pix = 4'd0;
            while (!check_inc && n < 300) begin
                if (draw_q) begin
                    if (cnt_status !== exp_pix) seq_err++;
                    exp_pix = (exp_pix == 4'd8) ? 4'd0 : exp_pix + 4'd1;
                    draws++;
                end else if (cnt_status !== 4'd0) begin
                    seq_err++;
                end
                if (ld_curr_into_prev) advs++;
                tick();
                n++;
            end
            if (check_inc) begin
                to_check = n;
                tick();
                grew = int'(ld_prev_into_q);
                n = 1;
                while (!food_en && n < 50) begin tick(); n++; end
                if (food_en) gap = n;
            end
        end
    endtask

    int tc, dr, ad, se, gr, gp, nz;

    initial begin
        rst = 1'b1; go = 1'b0; isDead = 1'b0; inc_length = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        tick(); tick();
        chk("reset_strobes", 32'(strb), 32'h0);
        chk("reset_cnt", 32'(cnt_status), 32'd0);
        chk("reset_length", 32'(length), 32'd4);
        chk("reset_dir", 32'(dir), 32'b100);

        rst = 1'b0;
        tick();
        chk("idle_strobes", 32'(strb), 32'h0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("init_strobes", 32'(strb), 32'h2400);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("load_strobes_%0d", i), 32'(strb), 32'h1800);
        end
        tick();
        chk("wait_idle_strobes", 32'(strb), 32'h0);
        key_down = 1'b1;
        #1;
        chk("wait_lock", 32'(strb), 32'h0001);

        run_frame(tc, dr, ad, se, gr, gp);
        chk("f1_to_check", 32'(tc), 32'd55);
        chk("f1_draws", 32'(dr), 32'd36);
        chk("f1_advs", 32'(ad), 32'd4);
        chk("f1_pix_order", 32'(se), 32'd0);
        chk("f1_no_grow", 32'(gr), 32'd0);
        chk("f1_gap", 32'(gp), 32'd6);
        chk("f1_dir_down_rejected", 32'(dir), 32'b100);
        chk("f1_length", 32'(length), 32'd4);

        key_down = 1'b0; key_right = 1'b1; inc_length = 1'b1;
        run_frame(tc, dr, ad, se, gr, gp);
        chk("f2_to_check", 32'(tc), 32'd55);
        chk("f2_grow", 32'(gr), 32'd1);
        chk("f2_gap", 32'(gp), 32'd7);
        chk("f2_dir_right", 32'(dir), 32'b001);
        chk("f2_length", 32'(length), 32'd5);

        key_right = 1'b0; key_up = 1'b1; key_left = 1'b1;
        run_frame(tc, dr, ad, se, gr, gp);
        chk("f3_to_check", 32'(tc), 32'd68);
        chk("f3_draws", 32'(dr), 32'd45);
        chk("f3_advs", 32'(ad), 32'd5);
        chk("f3_pix_order", 32'(se), 32'd0);
        chk("f3_max_no_grow", 32'(gr), 32'd0);
        chk("f3_gap", 32'(gp), 32'd6);
        chk("f3_dir_up_priority", 32'(dir), 32'b100);
        chk("f3_length_sat", 32'(length), 32'd5);

        key_up = 1'b0; key_left = 1'b0; isDead = 1'b1;
        run_frame(tc, dr, ad, se, gr, gp);
        chk("f4_to_check", 32'(tc), 32'd68);
        chk("f4_no_next_frame", 32'(gp), 32'hFFFF_FFFF);
        key_up = 1'b1;
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (strb !== 14'h0 || cnt_status !== 4'd0) nz++;
        end
        chk("dead_silent", 32'(nz), 32'd0);

        key_up = 1'b0; isDead = 1'b0; inc_length = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("restart_init", 32'(strb), 32'h2400);
        tick();
        chk("restart_length", 32'(length), 32'd4);
        chk("restart_load", 32'(strb), 32'h1800);

        key_right = 1'b1;
        nz = 0;
        while (!(draw_q && cnt_status == 4'd5) && nz < 200) begin tick(); nz++; end
        key_right = 1'b0;
        chk("reached_draw5", 32'(cnt_status), 32'd5);
        chk("pre_reset_dir", 32'(dir), 32'b001);
        rst = 1'b1;
        #1;
        chk("midreset_strobes", 32'(strb), 32'h0);
        chk("midreset_cnt", 32'(cnt_status), 32'd0);
        chk("midreset_length", 32'(length), 32'd4);
        chk("midreset_dir", 32'(dir), 32'b100);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_reset_idle", 32'(strb), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
